// File: rtl/pwm_axil_slave.sv
// AXI4-Lite register slave for the PWM IP: four 32-bit registers (CTRL, PERIOD,
// DUTY, PRESCALE) driving one double-buffered, glitch-free PWM output.
module pwm_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            pwm_out,
    output logic                            period_tick
);

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;
    logic      wr_en, rd_en;

    logic [3:0][C_S_AXI_DATA_WIDTH-1:0] regs;
    logic [C_S_AXI_DATA_WIDTH-1:0]      rdata_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]      wmask;
    logic [1:0]                         wr_idx, rd_idx;

    logic                 enable, polarity, tick, idle, wrap;
    logic [CNT_WIDTH-1:0] period_reg, duty_reg, prescale_reg;
    logic [CNT_WIDTH-1:0] per_sh, duty_sh, cnt, presc;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_idx = S_AXI_AWADDR[3:2];
    assign rd_idx = S_AXI_ARADDR[3:2];
    assign wmask  = {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}},
                     {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    // READY is raised a cycle after both valids are seen; the write lands on
    // the following edge, and only if both valids are still present.
    always_comb begin
        wr_next = wr_state;
        wr_en   = 1'b0;
        case (wr_state)
            W_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) wr_next = W_ACK;
            W_ACK: begin
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    wr_en   = 1'b1;
                    wr_next = W_RESP;
                end else begin
                    wr_next = W_IDLE;
                end
            end
            W_RESP: if (S_AXI_BREADY) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        rd_en   = 1'b0;
        case (rd_state)
            R_IDLE: if (S_AXI_ARVALID) rd_next = R_ACK;
            R_ACK: begin
                if (S_AXI_ARVALID) begin
                    rd_en   = 1'b1;
                    rd_next = R_DATA;
                end else begin
                    rd_next = R_IDLE;
                end
            end
            R_DATA: if (S_AXI_RREADY) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    assign S_AXI_AWREADY = (wr_state == W_ACK);
    assign S_AXI_WREADY  = (wr_state == W_ACK);
    assign S_AXI_BVALID  = (wr_state == W_RESP);
    assign S_AXI_BRESP   = '0;
    assign S_AXI_ARREADY = (rd_state == R_ACK);
    assign S_AXI_RVALID  = (rd_state == R_DATA);
    assign S_AXI_RRESP   = '0;
    assign S_AXI_RDATA   = rdata_q;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            regs <= '0;
        end else if (wr_en) begin
            regs[wr_idx] <= (regs[wr_idx] & ~wmask) | (S_AXI_WDATA & wmask);
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= regs[rd_idx];
        end
    end

    assign enable       = regs[0][0];
    assign polarity     = regs[0][1];
    assign period_reg   = regs[1][CNT_WIDTH-1:0];
    assign duty_reg     = regs[2][CNT_WIDTH-1:0];
    assign prescale_reg = regs[3][CNT_WIDTH-1:0];

    assign idle = !enable || (per_sh == '0);
    // >= rather than == so lowering PRESCALE mid-count cannot strand the prescaler
    assign tick = (presc >= prescale_reg);
    assign wrap = tick && (cnt == per_sh - CNT_ONE);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            per_sh      <= '0;
            duty_sh     <= '0;
            cnt         <= '0;
            presc       <= '0;
            period_tick <= 1'b0;
            pwm_out     <= 1'b0;
        end else begin
            pwm_out     <= (enable && (per_sh != '0) && (cnt < duty_sh)) ^ polarity;
            period_tick <= 1'b0;
            if (idle) begin
                per_sh  <= period_reg;
                duty_sh <= duty_reg;
                cnt     <= '0;
                presc   <= '0;
            end else if (tick) begin
                presc <= '0;
                if (wrap) begin
                    cnt         <= '0;
                    per_sh      <= period_reg;
                    duty_sh     <= duty_reg;
                    period_tick <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_ONE;
                end
            end else begin
                presc <= presc + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pwm_axil_slave.sv
// Self-checking bench for pwm_axil_slave: register table, handshake corner
// sequences, and PWM waveforms checked against an arithmetic reference.
`timescale 1ns/1ps
module tb_pwm_axil_slave;

    logic        tb_ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        pwm_out;
    logic        period_tick;

    pwm_axil_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4),
        .CNT_WIDTH(32)
    ) dut (
        .ACLK(tb_ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .pwm_out(pwm_out), .period_tick(period_tick)
    );

    always #5 tb_ACLK = ~tb_ACLK;

    int cyc = 0;
    always @(posedge tb_ACLK) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    int wr_cyc;

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit ok;
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_BREADY  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge tb_ACLK);
            if (S_AXI_AWREADY && S_AXI_WREADY) begin ok = 1'b1; break; end
        end
        check("aw_w_handshake", {31'b0, ok}, 32'd1);
        @(posedge tb_ACLK);
        #1;
        wr_cyc        = cyc;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge tb_ACLK);
            if (S_AXI_BVALID) begin ok = 1'b1; break; end
        end
        check("bvalid", {31'b0, ok}, 32'd1);
        check("bresp", {30'b0, S_AXI_BRESP}, 32'd0);
        @(posedge tb_ACLK);
        #1 S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        bit ok;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge tb_ACLK);
            if (S_AXI_ARREADY) begin ok = 1'b1; break; end
        end
        check("ar_handshake", {31'b0, ok}, 32'd1);
        @(posedge tb_ACLK);
        #1;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge tb_ACLK);
            if (S_AXI_RVALID) begin ok = 1'b1; break; end
        end
        check("rvalid", {31'b0, ok}, 32'd1);
        check("rresp", {30'b0, S_AXI_RRESP}, 32'd0);
        data = S_AXI_RDATA;
        @(posedge tb_ACLK);
        #1 S_AXI_RREADY = 1'b0;
    endtask

    // Reference PWM: cycle j after the enabling edge sits in prescaled slot
    // j/(P+1); slot s belongs to period s/per at position s%per. Output is
    // registered, so the sample after edge E+n reflects cycle n-1.
    int e_cyc, m_per, m_duty0, m_presc, m_len;
    bit m_pol;
    int dw_cyc, dw_val;
    bit dw_set;

    function automatic bit exp_pwm(input int n);
        int s, q, c, d;
        s = (n - 1) / (m_presc + 1);
        q = s / m_per;
        c = s % m_per;
        d = m_duty0;
        if (dw_set && q > 0 && dw_cyc < e_cyc + q * m_len) d = dw_val;
        return (c < d) ^ m_pol;
    endfunction

    task automatic pwm_start(input int per, input int duty, input int presc, input bit pol);
        axi_write(4'h0, 32'h0, 4'hF);
        axi_write(4'h4, per, 4'hF);
        axi_write(4'h8, duty, 4'hF);
        axi_write(4'hC, presc, 4'hF);
        m_per = per; m_duty0 = duty; m_presc = presc; m_pol = pol;
        m_len = (presc + 1) * per;
        dw_set = 1'b0;
        axi_write(4'h0, {30'b0, pol, 1'b1}, 4'hF);
        e_cyc = wr_cyc;
    endtask

    task automatic run_pwm(input int ncyc, input string tag);
        int n;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge tb_ACLK);
            n = cyc - e_cyc;
            check({tag, "_pwm"}, {31'b0, pwm_out}, {31'b0, exp_pwm(n)});
            check({tag, "_tick"}, {31'b0, period_tick}, {31'b0, (n % m_len) == 0});
        end
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [3:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];
    logic [31:0] mregs[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, snap;
        bit ok;
        int hs2, b_done;

        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        repeat (3) @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        check("rst_awready", {31'b0, S_AXI_AWREADY}, 0);
        check("rst_wready", {31'b0, S_AXI_WREADY}, 0);
        check("rst_bvalid", {31'b0, S_AXI_BVALID}, 0);
        check("rst_bresp", {30'b0, S_AXI_BRESP}, 0);
        check("rst_arready", {31'b0, S_AXI_ARREADY}, 0);
        check("rst_rvalid", {31'b0, S_AXI_RVALID}, 0);
        check("rst_rresp", {30'b0, S_AXI_RRESP}, 0);
        check("rst_rdata", S_AXI_RDATA, 0);
        check("rst_pwm", {31'b0, pwm_out}, 0);
        check("rst_tick", {31'b0, period_tick}, 0);
        @(posedge tb_ACLK);
        #1 ARESET = 1'b0;

        // Register map, byte strobes and address aliasing
        vecs[0] = '{4'h0, 32'h0101FFFF, 4'hF, 4'h0, 32'h0101FFFF};
        vecs[1] = '{4'h4, 32'hABCD0001, 4'hF, 4'h4, 32'hABCD0001};
        vecs[2] = '{4'h8, 32'hDEAD0011, 4'hF, 4'h8, 32'hDEAD0011};
        vecs[3] = '{4'hC, 32'hBEEF0011, 4'hF, 4'hC, 32'hBEEF0011};
        vecs[4] = '{4'h4, 32'hFFFFFFFF, 4'hF, 4'h4, 32'hFFFFFFFF};
        vecs[5] = '{4'h4, 32'h00000012, 4'h1, 4'h4, 32'hFFFFFF12};
        vecs[6] = '{4'h8, 32'h12345678, 4'hA, 4'h8, 32'h12AD5611};
        vecs[7] = '{4'hD, 32'h00000000, 4'h0, 4'hC, 32'hBEEF0011};
        vecs[8] = '{4'h3, 32'h00000000, 4'hF, 4'h2, 32'h00000000};
        vecs[9] = '{4'hE, 32'hCAFEF00D, 4'h3, 4'hF, 32'hBEEFF00D};
        for (int i = 0; i < 10; i++) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
            axi_read(vecs[i].raddr, rd);
            check($sformatf("vec%0d_read", i), rd, vecs[i].exp);
        end

        // Randomised register traffic against an array model
        for (int r = 0; r < 4; r++) begin
            mregs[r] = $urandom;
            axi_write(4'(r * 4), mregs[r], 4'hF);
        end
        for (int k = 0; k < 40; k++) begin
            logic [3:0]  a;
            logic [31:0] d;
            logic [3:0]  s;
            a = 4'($urandom_range(15, 0));
            if ($urandom_range(1, 0) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(15, 0));
                axi_write(a, d, s);
                for (int b = 0; b < 4; b++)
                    if (s[b]) mregs[a[3:2]][8*b +: 8] = d[8*b +: 8];
            end else begin
                axi_read(a, rd);
                check("rand_read", rd, mregs[a[3:2]]);
            end
        end
        axi_write(4'h0, 32'h0, 4'hF);

        // Basic waveform, then inverted polarity
        pwm_start(10, 3, 0, 1'b0);
        run_pwm(30, "t3");
        pwm_start(10, 3, 0, 1'b1);
        run_pwm(25, "t3inv");

        // DUTY rewritten mid-period takes effect from the next period only
        pwm_start(10, 3, 0, 1'b0);
        fork
            run_pwm(40, "t4");
            begin
                repeat (2) @(posedge tb_ACLK);
                #1;
                axi_write(4'h8, 32'd8, 4'hF);
                dw_cyc = wr_cyc;
                dw_val = 8;
                dw_set = 1'b1;
            end
        join
        pwm_start(10, 8, 1, 1'b0);
        run_pwm(45, "t4presc");
        axi_write(4'h0, 32'h0, 4'hF);

        // AWVALID ahead of WVALID, BREADY held off, second write stalled
        S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 32'h5555AAAA; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_BREADY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge tb_ACLK);
            check("t5_awready_aw_only", {31'b0, S_AXI_AWREADY}, 0);
            check("t5_wready_aw_only", {31'b0, S_AXI_WREADY}, 0);
        end
        @(posedge tb_ACLK);
        #1 S_AXI_WVALID = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge tb_ACLK);
            if (S_AXI_AWREADY) begin ok = 1'b1; break; end
        end
        check("t5_first_handshake", {31'b0, ok}, 1);
        @(posedge tb_ACLK);
        #1;
        S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h00000077;
        for (int i = 0; i < 4; i++) begin
            @(negedge tb_ACLK);
            check("t5_bvalid_hold", {31'b0, S_AXI_BVALID}, 1);
            check("t5_second_stall", {31'b0, S_AXI_AWREADY}, 0);
        end
        @(posedge tb_ACLK);
        #1 S_AXI_BREADY = 1'b1;
        @(posedge tb_ACLK);
        #1;
        b_done = cyc;
        check("t5_b_complete", {31'b0, S_AXI_BVALID}, 0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge tb_ACLK);
            if (S_AXI_AWREADY) begin ok = 1'b1; break; end
        end
        check("t5_second_handshake", {31'b0, ok}, 1);
        @(posedge tb_ACLK);
        #1;
        hs2 = cyc;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        check("t5_write_after_b", {31'b0, hs2 > b_done}, 1);
        @(negedge tb_ACLK);
        check("t5_second_bvalid", {31'b0, S_AXI_BVALID}, 1);
        @(posedge tb_ACLK);
        #1 S_AXI_BREADY = 1'b0;
        axi_read(4'hC, rd);
        check("t5_read_c", rd, 32'h00000077);

        // RREADY held off: RVALID and RDATA stay put
        S_AXI_ARADDR = 4'h8; S_AXI_ARVALID = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge tb_ACLK);
            if (S_AXI_ARREADY) begin ok = 1'b1; break; end
        end
        check("t5_ar_handshake", {31'b0, ok}, 1);
        @(posedge tb_ACLK);
        #1 S_AXI_ARVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge tb_ACLK);
            check("t5_rvalid_hold", {31'b0, S_AXI_RVALID}, 1);
            check("t5_rdata_hold", S_AXI_RDATA, 32'h5555AAAA);
        end
        @(posedge tb_ACLK);
        #1 S_AXI_RREADY = 1'b1;
        @(posedge tb_ACLK);
        #1 S_AXI_RREADY = 1'b0;
        check("t5_rvalid_drop", {31'b0, S_AXI_RVALID}, 0);

        // Read and write to the same register on the same edge: old value read
        S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h12340000; S_AXI_WSTRB = 4'hF;
        S_AXI_ARADDR = 4'hC;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge tb_ACLK);
            if (S_AXI_AWREADY && S_AXI_ARREADY) begin ok = 1'b1; break; end
        end
        check("t5_same_edge_ready", {31'b0, ok}, 1);
        @(posedge tb_ACLK);
        #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        @(negedge tb_ACLK);
        check("t5_same_edge_rvalid", {31'b0, S_AXI_RVALID}, 1);
        snap = S_AXI_RDATA;
        check("t5_same_edge_old", snap, 32'h00000077);
        @(posedge tb_ACLK);
        #1 begin S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0; end
        axi_read(4'hC, rd);
        check("t5_same_edge_new", rd, 32'h12340000);

        // Reset while a B response is pending and the PWM is running
        pwm_start(10, 3, 0, 1'b0);
        S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h99; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge tb_ACLK);
            if (S_AXI_AWREADY) break;
        end
        @(posedge tb_ACLK);
        #1 begin S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; end
        @(negedge tb_ACLK);
        check("t6_bvalid_before", {31'b0, S_AXI_BVALID}, 1);
        check("t6_pwm_before", {31'b0, pwm_out}, 1);
        #2 ARESET = 1'b1;
        #1;
        check("t6_bvalid_async", {31'b0, S_AXI_BVALID}, 0);
        check("t6_pwm_async", {31'b0, pwm_out}, 0);
        repeat (2) @(posedge tb_ACLK);
        #1 ARESET = 1'b0;
        for (int r = 0; r < 4; r++) begin
            axi_read(4'(r * 4), rd);
            check($sformatf("t6_reg%0d_cleared", r), rd, 32'h0);
        end
        @(negedge tb_ACLK);
        check("t6_pwm_idle", {31'b0, pwm_out}, 0);

        // Duty extremes
        pwm_start(5, 0, 0, 1'b0);
        run_pwm(20, "t6_duty0");
        pwm_start(5, 7, 0, 1'b0);
        run_pwm(20, "t6_dutyfull");

        // Randomised waveform configurations
        for (int k = 0; k < 6; k++) begin
            int p, d, ps;
            bit pl;
            p  = $urandom_range(12, 1);
            d  = $urandom_range(14, 0);
            ps = $urandom_range(2, 0);
            pl = 1'($urandom_range(1, 0));
            pwm_start(p, d, ps, pl);
            run_pwm(2 * (ps + 1) * p + 4, $sformatf("rand%0d", k));
        end
        axi_write(4'h0, 32'h0, 4'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwm_axil_slave.md
Name: pwm_axil_slave

Overview:
- AXI4-Lite responder for the PWM IP: it is the slave that the system's AXI4-Lite master BFM and the processor talk to.
- Holds four 32-bit read/write registers at offsets 0x0, 0x4, 0x8 and 0xC.
- Drives one PWM output from those registers.
- Double-buffered period/duty values update only on a PWM period boundary, so the output never glitches.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, address bits decoded; bits [3:2] select the register.
- CNT_WIDTH, 32, width of the PWM counter and prescaler.

Ports:
- ACLK  in  1  single clock for the whole block.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1; S_AXI_AWREADY  out  1.
- S_AXI_WDATA  in  32; S_AXI_WSTRB  in  4; S_AXI_WVALID  in  1; S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH; S_AXI_ARPROT  in  3  ignored; S_AXI_ARVALID  in  1; S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  32; S_AXI_RRESP  out  2; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1.
- pwm_out  out  1  PWM waveform.
- period_tick  out  1  one-cycle pulse when the counter wraps.

Behaviour:
- Reset (asynchronous): all registers, shadows, counter and prescaler clear to 0. All READY/VALID outputs, BRESP, RRESP, RDATA, pwm_out and period_tick are 0.
- Register map:
  - 0x0 CTRL: bit0 enable, bit1 polarity invert; bits 31:2 stored and read back.
  - 0x4 PERIOD.
  - 0x8 DUTY.
  - 0xC PRESCALE.
  - All 32 bits of every register are stored and read back exactly as written.
- Write channel:
  - AWREADY and WREADY assert together for exactly one cycle when AWVALID and WVALID are both high, no write is in progress, and BVALID is low.
  - A write is never accepted with only one of the two valids present.
  - The register updates on the handshake edge, per byte lane per WSTRB.
  - BVALID rises the next cycle with BRESP=00 and holds until BREADY. The next write is accepted no earlier than the cycle after B completes.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID is high and RVALID is low.
  - RDATA is captured on that edge; RVALID rises the next cycle with RRESP=00.
  - RDATA and RVALID are held stable until RREADY.
- Read and write channels are independent. If a read and a write to the same register handshake on the same edge, the read returns the old value.
- Only address bits [3:2] are decoded, so other offsets alias. RESP is always 00 (OKAY).
- Prescaler:
  - With enable high, the prescaler counts 0..PRESCALE.
  - tick occurs when prescaler==PRESCALE; the prescaler then returns to 0.
  - PRESCALE=0 gives a tick every cycle.
- PWM counter:
  - Advances on each tick, counting 0..per_sh-1.
  - On a tick with cnt==per_sh-1: cnt goes to 0, per_sh<=PERIOD, duty_sh<=DUTY, and period_tick pulses on the next cycle.
- pwm_out (registered, 1-cycle latency): (enable && per_sh!=0 && cnt<duty_sh) XOR polarity.
  - duty_sh>=per_sh gives constant active.
  - duty_sh=0 gives constant inactive.
- Shadow load while idle: when enable is low or per_sh==0, the shadows load continuously from PERIOD/DUTY, and the counter and prescaler are held at 0.
- Enable edges:
  - Clearing enable mid-period stops the counter immediately and forces the output inactive (equal to polarity) the next cycle.
  - Re-enabling starts a fresh period at cnt=0.
- Reset mid-transaction aborts it: VALID outputs drop asynchronously and no partial register write occurs.

Test Plan:
1. Reset, then write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x0, 0x4, 0x8, 0xC in turn and read each back -> each read equals the written value, all RESP=00.
2. Write 0xFFFFFFFF to 0x4, then 0x00000012 to 0x4 with WSTRB=0001 -> read of 0x4 returns 0xFFFFFF12.
3. PERIOD=10, DUTY=3, PRESCALE=0, CTRL=1 -> pwm_out is high for 3 cycles and low for 7, repeating; period_tick fires every 10 cycles. Then CTRL=3 -> high 7, low 3.
4. While running, write DUTY=8 mid-period -> the current period keeps 3 high cycles; the next period shows 8. PRESCALE=1 -> all durations double.
5. AWVALID held 5 cycles before WVALID, and BREADY held low 4 cycles -> no handshake until both are valid; BVALID is held; a second write stalls until B completes. RREADY held low -> RDATA stays stable.
6. Assert ARESET while BVALID=1 and the PWM is running -> BVALID, pwm_out and all registers read 0 after release; DUTY=0 or DUTY>=PERIOD gives constant inactive or constant active respectively.
